// File: rtl/inmultitor_refacere.sv
// Reconstructs a dividend p = q*b + r with a shift-and-add multiplier.
// One launch takes N iteration cycles plus a single result cycle.
module inmultitor_refacere #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   q,
    input  logic [N-1:0]   b,
    input  logic [N-1:0]   r,
    output logic [2*N-1:0] p,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e         state;
    logic [N-1:0]   q_reg;
    logic [2*N-1:0] b_reg;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            q_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            p     <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        q_reg <= q;
                        b_reg <= {{N{1'b0}}, b};
                        // Remainder seeds the accumulator so no final add is needed.
                        acc   <= {{N{1'b0}}, r};
                        cnt   <= '0;
                        err   <= (r >= b);
                        state <= StIter;
                    end
                end
                StIter: begin
                    if (q_reg[0]) begin
                        acc <= acc + b_reg;
                    end
                    q_reg <= q_reg >> 1;
                    b_reg <= b_reg << 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    p     <= acc;
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy = (state != StIdle);

endmodule

// File: tb/tb_inmultitor_refacere.sv
// Scoreboard bench for inmultitor_refacere: stimulus pushes expected results,
// a negedge monitor pops and checks value, err flag and done timing.
module tb_inmultitor_refacere;

    localparam int unsigned N = 4;

    typedef struct {
        logic [2*N-1:0] p;
        logic           err;
        int             due;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   q = '0;
    logic [N-1:0]   b = '0;
    logic [N-1:0]   r = '0;
    logic [2*N-1:0] p;
    logic           busy;
    logic           done;
    logic           err;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   done_seen = 0;

    inmultitor_refacere #(.N(N)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .q    (q),
        .b    (b),
        .r    (r),
        .p    (p),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("p", 32'(p), 32'(e.p));
                check("err", 32'(err), 32'(e.err));
                check("done_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called at posedge+1: operands are sampled at the next edge.
    task automatic launch(input logic [N-1:0] qi, input logic [N-1:0] bi, input logic [N-1:0] ri,
                          input logic [2*N-1:0] pe, input logic ee, input bit expect_done);
        exp_t e;
        q = qi;
        b = bi;
        r = ri;
        start = 1'b1;
        if (expect_done) begin
            e.p = pe;
            e.err = ee;
            e.due = cyc + 1 + N + 1;
            sb.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [N-1:0] qi, input logic [N-1:0] bi, input logic [N-1:0] ri,
                          input logic [2*N-1:0] pe, input logic ee);
        launch(qi, bi, ri, pe, ee, 1'b1);
        step(1);
        start = 1'b0;
        step(N + 3);
    endtask

    initial begin
        int seen;
        step(2);
        check("reset_p", 32'(p), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        reset = 1'b0;
        step(1);

        single(4'd4, 4'd3, 4'd2, 8'd14, 1'b0);
        single(4'd15, 4'd15, 4'd14, 8'd239, 1'b0);
        single(4'd5, 4'd0, 4'd3, 8'd3, 1'b1);
        single(4'd2, 4'd3, 4'd3, 8'd9, 1'b1);

        // Start and new operands during ITER must be ignored: 7*9+5 = 68.
        launch(4'd7, 4'd9, 4'd5, 8'd68, 1'b0, 1'b1);
        step(1);
        start = 1'b0;
        step(1);
        launch(4'd15, 4'd15, 4'd15, 8'd0, 1'b0, 1'b0);
        check("busy_iter", 32'(busy), 32'd1);
        step(2);
        start = 1'b0;
        step(N + 2);

        // Reset on third ITER cycle aborts without a done pulse.
        launch(4'd6, 4'd6, 4'd1, 8'd0, 1'b0, 1'b0);
        step(1);
        start = 1'b0;
        step(2);
        seen = done_seen;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("abort_p", 32'(p), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        step(10);
        check("abort_no_done", 32'(done_seen), 32'(seen));

        // Start held high: launches every N+2 cycles with current operands.
        launch(4'd3, 4'd5, 4'd1, 8'd16, 1'b0, 1'b1);
        step(N + 2);
        launch(4'd12, 4'd10, 4'd11, 8'd131, 1'b1, 1'b1);
        step(N + 2);
        launch(4'd9, 4'd13, 4'd0, 8'd117, 1'b0, 1'b1);
        step(1);
        start = 1'b0;

        for (int i = 0; i < 100 && sb.size() != 0; i++) step(1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("total_done", 32'(done_seen), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/inmultitor_refacere.md
INMULTITOR_REFACERE -- requirements
Module: inmultitor_refacere

Interface
REQ-001 Parameter N, default 4, operand width; shall support N >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to launch one reconstruction; sampled only in IDLE.
REQ-005 q  input  N  quotient, unsigned.
REQ-006 b  input  N  divisor, unsigned.
REQ-007 r  input  N  remainder, unsigned.
REQ-008 p  output  2N  reconstructed dividend p = q*b + r, unsigned, registered.
REQ-009 busy  output  1  high while an operation is in progress (ITER and DONE states).
REQ-010 done  output  1  one-cycle pulse when p becomes valid.
REQ-011 err  output  1  registered; high when latched r >= latched b (includes b == 0).

Function
REQ-012 FSM states IDLE, ITER, DONE; encoding free; no other reachable states.
REQ-013 IDLE: on start=1, latch q, b, r into internal registers, set acc = r zero-extended to 2N bits, bit counter = 0, err = (r >= b), go to ITER; otherwise stay in IDLE.
REQ-014 ITER: each cycle: if q_reg[0]=1 then acc += b_reg (b_reg held 2N bits wide); q_reg shifts right 1; b_reg shifts left 1; counter increments.
REQ-015 ITER lasts exactly N cycles; after the N-th update go to DONE.
REQ-016 DONE: p <= acc, done = 1 for exactly that cycle, then go to IDLE unconditionally.
REQ-017 Latency: start sampled at edge k gives done=1 and valid p after edge k+N+1; a new start is accepted from edge k+N+2 onward.
REQ-018 Width: max result (2^N-1)^2 + (2^N-1) < 2^(2N); no overflow, no saturation, no truncation.
REQ-019 start while busy=1 shall be ignored; latched operands shall not change during an operation.
REQ-020 Input changes on q, b and r after the start edge shall not affect the result.
REQ-021 p and err shall hold their last values until the next DONE or reset; err is set at launch and is valid with done.
REQ-022 err is advisory only; the result is still computed as q*b + r.
REQ-023 start held high continuously: a new operation is launched at the first IDLE cycle after each DONE.

Reset
REQ-024 reset=1 at a rising edge: state IDLE, p=0, done=0, busy=0, err=0; all internal registers cleared.
REQ-025 Reset has priority over start and over every state transition.
REQ-026 Reset asserted mid-ITER or in DONE aborts the operation; no done pulse for the aborted operation.

Verification
REQ-027 Reset held 2 cycles, start=0 -> p=0, done=0, busy=0, err=0.
REQ-028 q=4'b0100, b=4'b0011, r=4'b0010, start pulse -> exactly one done pulse, 5 cycles after the start edge, p=8'd14, err=0.
REQ-029 q=4'b1111, b=4'b1111, r=4'b1110 -> p=8'd239, err=0.
REQ-030 q=4'd5, b=4'd0, r=4'd3 -> p=8'd3, err=1; q=4'd2, b=4'd3, r=4'd3 -> p=8'd9, err=1.
REQ-031 Start pulse, then start=1 and changed q/b/r on ITER cycle 2 -> ignored; result matches the first operands. Reset on ITER cycle 3 -> IDLE, p=0, no done.
REQ-032 start held high for 3 operations -> done pulses exactly 6 cycles apart, with p correct for the operands present at each launch edge.
